// File: rtl/l2_conv_sequencer.sv
// l2_conv_sequencer: control sequencer for the layer-2 convolution datapath.
// Loads the L2 input buffer, then four filters, then for each window clears
// the window/accumulators, fills the window, runs the MAC pass and writes
// one OFM word. All outputs are registered alongside the state.
// Optional build macro: L2_PERF_CNT_EN adds the busy_cycles counter output.
module l2_conv_sequencer #(
    parameter int BUF_DEPTH = 64,
    parameter int FILT_LEN  = 16,
    parameter int WIN_LEN   = 16,
    parameter int NUM_WIN   = 48,
    parameter int STRIDE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    output logic        done,
    output logic        wEnBuff,
    output logic [5:0]  buffAddress,
    output logic [3:0]  wEnFilter,
    output logic [5:0]  filterCount,
    output logic        writeEnwindow,
    output logic        winRst,
    output logic        readEnmac,
    output logic        addEn,
    output logic [5:0]  macCount,
    output logic        wrofm,
    output logic [7:0]  ofmaddr
`ifdef L2_PERF_CNT_EN
    ,
    output logic [15:0] busy_cycles
`endif
);

    localparam logic [5:0] BUF_LAST  = 6'(BUF_DEPTH - 1);
    localparam logic [5:0] FILT_LAST = 6'(FILT_LEN - 1);
    localparam logic [5:0] WIN_LAST  = 6'(WIN_LEN - 1);
    localparam logic [7:0] WIDX_LAST = 8'(NUM_WIN - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_BUF, LOAD_FILT, WIN_RST, WIN_FILL, MAC, WRITE, DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [1:0]  filtSel;
    logic [7:0]  winIdx;
    logic [5:0]  winBase;

    // Window start address; the 6-bit truncation gives the modulo-64 wrap.
    assign winBase = 6'(32'(winIdx) * STRIDE);
    assign ofmaddr = winIdx;

    // Sequencer FSM: each branch sets the registered outputs of the state it enters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            filtSel       <= '0;
            winIdx        <= '0;
            ready         <= 1'b1;
            done          <= 1'b0;
            wEnBuff       <= 1'b0;
            buffAddress   <= '0;
            wEnFilter     <= '0;
            filterCount   <= '0;
            writeEnwindow <= 1'b0;
            winRst        <= 1'b0;
            readEnmac     <= 1'b0;
            addEn         <= 1'b0;
            macCount      <= '0;
            wrofm         <= 1'b0;
        end else begin
            done          <= 1'b0;
            wEnBuff       <= 1'b0;
            buffAddress   <= '0;
            wEnFilter     <= '0;
            filterCount   <= '0;
            writeEnwindow <= 1'b0;
            winRst        <= 1'b0;
            readEnmac     <= 1'b0;
            addEn         <= 1'b0;
            macCount      <= '0;
            wrofm         <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start) begin
                        state       <= LOAD_BUF;
                        cnt         <= '0;
                        winIdx      <= '0;
                        ready       <= 1'b0;
                        wEnBuff     <= 1'b1;
                        buffAddress <= '0;
                    end
                end
                LOAD_BUF: begin
                    if (cnt == BUF_LAST) begin
                        state       <= LOAD_FILT;
                        cnt         <= '0;
                        filtSel     <= '0;
                        wEnFilter   <= 4'b0001;
                        filterCount <= '0;
                    end else begin
                        cnt         <= cnt + 6'd1;
                        wEnBuff     <= 1'b1;
                        buffAddress <= cnt + 6'd1;
                    end
                end
                LOAD_FILT: begin
                    if (cnt == FILT_LAST) begin
                        cnt <= '0;
                        if (filtSel == 2'd3) begin
                            state  <= WIN_RST;
                            winIdx <= '0;
                            winRst <= 1'b1;
                        end else begin
                            filtSel     <= filtSel + 2'd1;
                            wEnFilter   <= 4'b0001 << (filtSel + 2'd1);
                            filterCount <= '0;
                        end
                    end else begin
                        cnt         <= cnt + 6'd1;
                        wEnFilter   <= 4'b0001 << filtSel;
                        filterCount <= cnt + 6'd1;
                    end
                end
                WIN_RST: begin
                    state         <= WIN_FILL;
                    cnt           <= '0;
                    writeEnwindow <= 1'b1;
                    buffAddress   <= winBase;
                end
                WIN_FILL: begin
                    if (cnt == WIN_LAST) begin
                        state     <= MAC;
                        cnt       <= '0;
                        readEnmac <= 1'b1;
                        addEn     <= 1'b1;
                        macCount  <= '0;
                    end else begin
                        cnt           <= cnt + 6'd1;
                        writeEnwindow <= 1'b1;
                        buffAddress   <= winBase + cnt + 6'd1;
                    end
                end
                MAC: begin
                    if (cnt == WIN_LAST) begin
                        state <= WRITE;
                        cnt   <= '0;
                        wrofm <= 1'b1;
                    end else begin
                        cnt       <= cnt + 6'd1;
                        readEnmac <= 1'b1;
                        addEn     <= 1'b1;
                        macCount  <= cnt + 6'd1;
                    end
                end
                WRITE: begin
                    if (winIdx == WIDX_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= WIN_RST;
                        winIdx <= winIdx + 8'd1;
                        winRst <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ready  <= 1'b1;
                    winIdx <= '0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef L2_PERF_CNT_EN
    // Count cycles spent away from IDLE, saturating; restart on each accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cycles <= '0;
        end else if (state == IDLE && start) begin
            busy_cycles <= '0;
        end else if (!ready && busy_cycles != 16'hFFFF) begin
            busy_cycles <= busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_conv_sequencer.sv
// Scoreboard bench for l2_conv_sequencer: stimulus pushes the expected event
// stream (cycle, kind, payload); per-instance monitors pop and compare.
module tb_l2_conv_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    ev_t q0[$];
    ev_t q1[$];

    logic       ready0, done0, wEnBuff0, writeEnwindow0, winRst0, readEnmac0, addEn0, wrofm0;
    logic [5:0] buffAddress0, filterCount0, macCount0;
    logic [3:0] wEnFilter0;
    logic [7:0] ofmaddr0;
    logic       ready1, done1, wEnBuff1, writeEnwindow1, winRst1, readEnmac1, addEn1, wrofm1;
    logic [5:0] buffAddress1, filterCount1, macCount1;
    logic [3:0] wEnFilter1;
    logic [7:0] ofmaddr1;
`ifdef L2_PERF_CNT_EN
    logic [15:0] busy0, busy1;
`endif

    l2_conv_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start0), .ready(ready0), .done(done0),
        .wEnBuff(wEnBuff0), .buffAddress(buffAddress0), .wEnFilter(wEnFilter0),
        .filterCount(filterCount0), .writeEnwindow(writeEnwindow0), .winRst(winRst0),
        .readEnmac(readEnmac0), .addEn(addEn0), .macCount(macCount0),
        .wrofm(wrofm0), .ofmaddr(ofmaddr0)
`ifdef L2_PERF_CNT_EN
        , .busy_cycles(busy0)
`endif
    );

    l2_conv_sequencer #(.NUM_WIN(16), .STRIDE(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .ready(ready1), .done(done1),
        .wEnBuff(wEnBuff1), .buffAddress(buffAddress1), .wEnFilter(wEnFilter1),
        .filterCount(filterCount1), .writeEnwindow(writeEnwindow1), .winRst(winRst1),
        .readEnmac(readEnmac1), .addEn(addEn1), .macCount(macCount1),
        .wrofm(wrofm1), .ofmaddr(ofmaddr1)
`ifdef L2_PERF_CNT_EN
        , .busy_cycles(busy1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Classify one sampled cycle into an event; more than one strobe is kind 15.
    function automatic ev_t mkEv(input logic [31:0] c, input logic prevRdy, input logic rdy,
                                 input logic dn, input logic wb, input logic [5:0] ba,
                                 input logic [3:0] wf, input logic [5:0] fc, input logic wew,
                                 input logic wr, input logic rm, input logic ae,
                                 input logic [5:0] mc, input logic wo, input logic [7:0] oa);
        ev_t e;
        logic [7:0] m;
        m = {rdy & ~prevRdy, dn, wo, rm | ae, wew, wr, |wf, wb};
        e.cyc = c;
        e.kind = 4'd0;
        e.val = 16'd0;
        if ($countones(m) > 1) begin
            e.kind = 4'd15; e.val = {8'd0, m};
        end else if (wb) begin
            e.kind = 4'd1; e.val = {rdy, 1'b0, oa, ba};
        end else if (|wf) begin
            e.kind = 4'd2; e.val = {rdy, 5'd0, wf, fc};
        end else if (wr) begin
            e.kind = 4'd3; e.val = {rdy, 7'd0, oa};
        end else if (wew) begin
            e.kind = 4'd4; e.val = {rdy, 1'b0, oa, ba};
        end else if (rm | ae) begin
            e.kind = 4'd5; e.val = {rdy, 3'd0, rm, ae, 4'd0, mc};
        end else if (wo) begin
            e.kind = 4'd6; e.val = {rdy, 7'd0, oa};
        end else if (dn) begin
            e.kind = 4'd7; e.val = {rdy, 7'd0, oa};
        end else if (m[7]) begin
            e.kind = 4'd8; e.val = {8'd0, oa};
        end
        return e;
    endfunction

    task automatic pushEv(input int sel, input int c, input int kind, input logic [15:0] val);
        ev_t e;
        e.cyc = 32'(c);
        e.kind = 4'(kind);
        e.val = val;
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Expected stream from load start up to the last WRITE of a run sampled in cycle t0.
    task automatic pushRun(input int sel, input int t0, input int stride, input int nw);
        int c;
        c = t0 + 1;
        for (int k = 0; k < 64; k++) begin
            pushEv(sel, c, 1, {2'b00, 8'd0, 6'(k)}); c++;
        end
        for (int f = 0; f < 4; f++) begin
            for (int t = 0; t < 16; t++) begin
                pushEv(sel, c, 2, {6'd0, 4'(1 << f), 6'(t)}); c++;
            end
        end
        for (int w = 0; w < nw; w++) begin
            pushEv(sel, c, 3, {8'd0, 8'(w)}); c++;
            for (int j = 0; j < 16; j++) begin
                pushEv(sel, c, 4, {2'b00, 8'(w), 6'((w * stride + j) % 64)}); c++;
            end
            for (int j = 0; j < 16; j++) begin
                pushEv(sel, c, 5, {4'd0, 2'b11, 4'd0, 6'(j)}); c++;
            end
            pushEv(sel, c, 6, {8'd0, 8'(w)}); c++;
        end
    endtask

    // Monitor for the default-parameter instance.
    initial begin
        logic prev;
        ev_t  e, x;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else begin
                e = mkEv(32'(cyc), prev, ready0, done0, wEnBuff0, buffAddress0, wEnFilter0,
                         filterCount0, writeEnwindow0, winRst0, readEnmac0, addEn0,
                         macCount0, wrofm0, ofmaddr0);
                prev = ready0;
                if (e.kind != 4'd0) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut0 unexpected event: got %h expected none", e);
                    end else begin
                        x = q0.pop_front();
                        check("dut0 event", 64'(e), 64'(x));
                    end
                end
            end
        end
    end

    // Monitor for the STRIDE=4, NUM_WIN=16 instance.
    initial begin
        logic prev;
        ev_t  e, x;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 1'b1;
            end else begin
                e = mkEv(32'(cyc), prev, ready1, done1, wEnBuff1, buffAddress1, wEnFilter1,
                         filterCount1, writeEnwindow1, winRst1, readEnmac1, addEn1,
                         macCount1, wrofm1, ofmaddr1);
                prev = ready1;
                if (e.kind != 4'd0) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut1 unexpected event: got %h expected none", e);
                    end else begin
                        x = q1.pop_front();
                        check("dut1 event", 64'(e), 64'(x));
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        check("dut0 reset outputs",
              64'({ready0, done0, wEnBuff0, buffAddress0, wEnFilter0, filterCount0,
                   writeEnwindow0, winRst0, readEnmac0, addEn0, macCount0, wrofm0, ofmaddr0}),
              64'({1'b1, 37'd0}));
        check("dut1 reset outputs",
              64'({ready1, done1, wEnBuff1, buffAddress1, wEnFilter1, filterCount1,
                   writeEnwindow1, winRst1, readEnmac1, addEn1, macCount1, wrofm1, ofmaddr1}),
              64'({1'b1, 37'd0}));
`ifdef L2_PERF_CNT_EN
        check("dut0 busy reset", 64'(busy0), 64'd0);
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single default run: done at +1761, ready back at +1762.
        t0 = cyc;
        pushRun(0, t0, 1, 48);
        pushEv(0, t0 + 1761, 7, {8'd0, 8'd47});
        pushEv(0, t0 + 1762, 8, 16'd0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (1770) @(posedge clk);
        #1;
`ifdef L2_PERF_CNT_EN
        check("dut0 busy after run", 64'(busy0), 64'd1761);
`endif

        // Stride 4, 16 windows: fill addresses wrap in window 15; done at +673.
        t0 = cyc;
        pushRun(1, t0, 4, 16);
        pushEv(1, t0 + 673, 7, {8'd0, 8'd15});
        pushEv(1, t0 + 674, 8, 16'd0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (680) @(posedge clk);
        #1;
`ifdef L2_PERF_CNT_EN
        check("dut1 busy after run", 64'(busy1), 64'd673);
`endif

        // Start held high with a re-pulse mid-run: one run, then a re-trigger from IDLE.
        t0 = cyc;
        pushRun(0, t0, 1, 48);
        pushEv(0, t0 + 1761, 7, {8'd0, 8'd47});
        pushEv(0, t0 + 1762, 8, 16'd0);
        pushRun(0, t0 + 1762, 1, 48);
        pushEv(0, t0 + 1762 + 1761, 7, {8'd0, 8'd47});
        pushEv(0, t0 + 1762 + 1762, 8, 16'd0);
        start0 = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b1;
        repeat (1361) @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (1370) @(posedge clk);
        #1;
`ifdef L2_PERF_CNT_EN
        check("dut0 busy after retrigger", 64'(busy0), 64'd1761);
`endif

        // Reset during the MAC pass of window 10 (cycle +490), then a fresh run.
        t0 = cyc;
        pushRun(0, t0, 1, 48);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (489) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("dut0 abort outputs",
              64'({ready0, done0, wEnBuff0, buffAddress0, wEnFilter0, filterCount0,
                   writeEnwindow0, winRst0, readEnmac0, addEn0, macCount0, wrofm0, ofmaddr0}),
              64'({1'b1, 37'd0}));
        q0.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        pushRun(0, t0, 1, 48);
        pushEv(0, t0 + 1761, 7, {8'd0, 8'd47});
        pushEv(0, t0 + 1762, 8, 16'd0);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (1770) @(posedge clk);
        #1;
`ifdef L2_PERF_CNT_EN
        check("dut0 busy after replay", 64'(busy0), 64'd1761);
`endif

        check("dut0 events outstanding", 64'(q0.size()), 64'd0);
        check("dut1 events outstanding", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_conv_sequencer.md
Name: l2_conv_sequencer

Overview:
- Sequencer for the layer-2 convolution datapath (DataPath_L2).
- Starts when the layer-1 controller reports its output feature maps are complete.
- Loads the L2 input buffer from the four layer-1 OFM ports, then loads four filters.
- Slides a window across the buffer, runs one MAC pass per window and writes one L2 OFM word per window.

Parameters:
- BUF_DEPTH, 64, words loaded into the L2 input buffer (at most 64, since buffAddress is 6 bits).
- FILT_LEN, 16, taps per filter (at most 64).
- WIN_LEN, 16, taps per window; equals the number of MAC cycles.
- NUM_WIN, 48, windows per run (at most 256, since ofmaddr is 8 bits).
- STRIDE, 1, buffer-address step between consecutive windows.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request from the L1 controller; sampled only in IDLE.
- ready  out  1  high in IDLE, low while the sequence runs.
- done  out  1  one-cycle pulse in the DONE state.
- wEnBuff  out  1  L2 buffer write enable.
- buffAddress  out  6  L2 buffer address, used for both load and window fill.
- wEnFilter  out  4  one-hot filter write enable.
- filterCount  out  6  tap index within the filter being loaded.
- writeEnwindow  out  1  window register load enable.
- winRst  out  1  clears the window and the accumulators.
- readEnmac  out  1  MAC read enable.
- addEn  out  1  accumulate enable.
- macCount  out  6  MAC tap index.
- wrofm  out  1  L2 OFM write strobe.
- ofmaddr  out  8  L2 OFM write address, equal to the window index.

Behaviour:
- Reset (rst=0): asynchronous entry to IDLE. All enables, counters and addresses go to 0, ready=1, done=0. Reset mid-run aborts at once; the next cycle after rst is released is IDLE.
- Outputs are Moore, decoded from the state and counters. No output depends combinationally on start.
- IDLE: ready=1. If start=1, go to LOAD_BUF on the next edge. start in any other state is ignored and is not queued.
- LOAD_BUF: wEnBuff=1 and buffAddress=k for k=0..BUF_DEPTH-1, one word per cycle. After k=BUF_DEPTH-1, go to LOAD_FILT.
- LOAD_FILT: for f=0..3, wEnFilter=(1<<f) and filterCount=t for t=0..FILT_LEN-1. This takes 4*FILT_LEN cycles. After f=3 and t=FILT_LEN-1, go to WIN_RST with window index w=0.
- WIN_RST: one cycle, winRst=1, all other enables 0.
- WIN_FILL: WIN_LEN cycles with writeEnwindow=1 and buffAddress=(w*STRIDE+j) mod 64, for j=0..WIN_LEN-1. The address wraps modulo 64 by 6-bit truncation; no error is flagged.
- MAC: WIN_LEN cycles with readEnmac=1, addEn=1 and macCount=0..WIN_LEN-1.
- WRITE: one cycle, wrofm=1, ofmaddr=w.
  - If w<NUM_WIN-1: increment w and go to WIN_RST.
  - Otherwise go to DONE.
- DONE: one cycle, done=1, ready=0, then IDLE. ready returns to 1 on the following cycle.
- ofmaddr holds w in every state after LOAD_FILT and is 0 in IDLE and in the load states.
- Latency with default parameters: start is sampled at cycle 0.
  - LOAD_BUF: cycles 1-64.
  - LOAD_FILT: cycles 65-128.
  - Windows: 34 cycles each (1+16+16+1), cycles 129-1760.
  - DONE: cycle 1761.
- Counters are independent, each reset to 0 on entering its state. Parameters outside their legal limits are a configuration error; no runtime checking is done.

Optional Feature:
- Macro: L2_PERF_CNT_EN.
- Defined:
  - Adds output busy_cycles (16 bits), cleared on the IDLE-to-LOAD_BUF transition.
  - Increments every cycle with ready=0, saturating at 0xFFFF.
  - Holds its value in IDLE until the next start; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then one start pulse at cycle 0 -> wEnBuff high for cycles 1-64 with buffAddress 0..63; done pulses at cycle 1761; ready returns high at cycle 1762.
- Filter load -> wEnFilter steps 0001, 0010, 0100, 1000, each held for 16 cycles with filterCount 0..15; no overlap with wEnBuff.
- Window w=5 -> winRst for 1 cycle; buffAddress 5..20 with writeEnwindow; macCount 0..15 with addEn; then wrofm=1 with ofmaddr=5.
- STRIDE=4, NUM_WIN=16 -> window 15 fill addresses 60,61,62,63,0,1,...,11 (wrap); 16 wrofm pulses, last at ofmaddr=15.
- start held high for the whole run plus a second pulse mid-run -> exactly one run, 48 wrofm pulses; the held start re-triggers only after returning to IDLE.
- rst pulled low during MAC of window 10 -> all enables 0 and ready=1 immediately; a fresh start replays from LOAD_BUF. With L2_PERF_CNT_EN defined: busy_cycles=1761 after a complete default run.
